alu_seq_driver: RTL and testbench

ALU_SEQ_DRIVER -- requirements
Module: alu_seq_driver

---
 rtl/alu_seq_driver.sv | 159 +++++++++++++++
 tb/tb_alu_seq_driver.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_driver.sv
// alu_seq_driver: sequences one request at a time onto a combinational ALU.
// The block registers the operands, waits SETTLE_CYCLES edges for the ALU to settle,
// captures the result, and presents it on a valid/ready response port.
// SETTLE_CYCLES must be in the range 1..15.
module alu_seq_driver #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,

    // request side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_op,
    input  logic [2:0]  req_flag_sel,
    input  logic [4:0]  req_shamt,
    input  logic        req_islog,
    input  logic        req_dir,

    // ALU drive side
    output logic [31:0] data1,
    output logic [31:0] data2,
    output logic [2:0]  opSwitch,
    output logic [2:0]  flagSwitch,
    output logic [4:0]  shamt,
    output logic        isLog,
    output logic        dir,
    input  logic [31:0] alu_result,
    input  logic        alu_flag,

    // response side
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_flag,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Counter preload: the edge that sees zero is the sampling edge, so the
    // accept-to-response latency is exactly SETTLE_CYCLES edges.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] settle_cnt;
    logic       accept;
    logic       sample;
    logic       handshake;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others regardless of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, handshake outputs and one-cycle event strobes.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        sample     = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (settle_cnt == 4'd0) begin
                    sample     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    handshake  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Settle counter: preloaded on accept, counts down while driving.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            settle_cnt <= 4'd0;
        end else if (accept) begin
            settle_cnt <= SETTLE_LOAD;
        end else if (state == DRIVE && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    // ALU drive registers: loaded only on accept, held in every other state
    // so later request-side changes cannot disturb an in-flight operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data1      <= 32'd0;
            data2      <= 32'd0;
            opSwitch   <= 3'd0;
            flagSwitch <= 3'd0;
            shamt      <= 5'd0;
            isLog      <= 1'b0;
            dir        <= 1'b0;
        end else if (accept) begin
            data1      <= req_a;
            data2      <= req_b;
            opSwitch   <= req_op;
            flagSwitch <= req_flag_sel;
            shamt      <= req_shamt;
            isLog      <= req_islog;
            dir        <= req_dir;
        end
    end

    // Response capture on the final settle edge; stable until the handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_result <= 32'd0;
            rsp_flag   <= 1'b0;
        end else if (sample) begin
            rsp_result <= alu_result;
            rsp_flag   <= alu_flag;
        end
    end

    // Completed-response counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_count <= 16'd0;
        end else if (handshake) begin
            op_count <= op_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_seq_driver.sv
// Self-checking bench for alu_seq_driver: one instance with SETTLE_CYCLES=1
// and one with SETTLE_CYCLES=4, each closed around an adder/compare ALU stub.
module tb_alu_seq_driver;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [2:0]  fs;
        logic [4:0]  sh;
        logic        il;
        logic        dr;
        logic [31:0] exp_result;
        logic        exp_flag;
        logic [15:0] exp_count;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_op;
    logic [2:0]  req_flag_sel;
    logic [4:0]  req_shamt;
    logic        req_islog;
    logic        req_dir;

    // instance with SETTLE_CYCLES=1
    logic        req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_flag1;
    logic [31:0] data1_1, data2_1, rsp_result1, alu_result1;
    logic [2:0]  op_1, fs_1;
    logic [4:0]  shamt_1;
    logic        islog_1, dir_1, alu_flag1;
    logic [15:0] op_count1;

    // instance with SETTLE_CYCLES=4
    logic        req_valid4, req_ready4, rsp_valid4, rsp_ready4, rsp_flag4;
    logic [31:0] data1_4, data2_4, rsp_result4, alu_result4;
    logic [2:0]  op_4, fs_4;
    logic [4:0]  shamt_4;
    logic        islog_4, dir_4, alu_flag4;
    logic [15:0] op_count4;

    int n_checks = 0;
    int n_pass   = 0;

    // ALU stubs
    assign alu_result1 = data1_1 + data2_1;
    assign alu_flag1   = (data1_1 > data2_1);
    assign alu_result4 = data1_4 + data2_4;
    assign alu_flag4   = (data1_4 > data2_4);

    alu_seq_driver #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_flag_sel(req_flag_sel),
        .req_shamt(req_shamt), .req_islog(req_islog), .req_dir(req_dir),
        .data1(data1_1), .data2(data2_1), .opSwitch(op_1), .flagSwitch(fs_1),
        .shamt(shamt_1), .isLog(islog_1), .dir(dir_1),
        .alu_result(alu_result1), .alu_flag(alu_flag1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_result(rsp_result1), .rsp_flag(rsp_flag1), .op_count(op_count1)
    );

    alu_seq_driver #(.SETTLE_CYCLES(4)) u4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid4), .req_ready(req_ready4),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_flag_sel(req_flag_sel),
        .req_shamt(req_shamt), .req_islog(req_islog), .req_dir(req_dir),
        .data1(data1_4), .data2(data2_4), .opSwitch(op_4), .flagSwitch(fs_4),
        .shamt(shamt_4), .isLog(islog_4), .dir(dir_4),
        .alu_result(alu_result4), .alu_flag(alu_flag4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
        .rsp_result(rsp_result4), .rsp_flag(rsp_flag4), .op_count(op_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // one rising edge, then return on the falling edge for sampling/driving
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input vec_t v);
        req_a        = v.a;
        req_b        = v.b;
        req_op       = v.op;
        req_flag_sel = v.fs;
        req_shamt    = v.sh;
        req_islog    = v.il;
        req_dir      = v.dr;
    endtask

    // full transaction on the SETTLE_CYCLES=1 instance with rsp_ready held high
    task automatic run_vec1(input vec_t v);
        set_req(v);
        req_valid1 = 1'b1;
        rsp_ready1 = 1'b1;
        step();
        req_valid1 = 1'b0;
        check("u1 data1", data1_1, v.a);
        check("u1 data2", data2_1, v.b);
        check("u1 opSwitch", 32'(op_1), 32'(v.op));
        check("u1 flagSwitch", 32'(fs_1), 32'(v.fs));
        check("u1 shamt", 32'(shamt_1), 32'(v.sh));
        check("u1 isLog", 32'(islog_1), 32'(v.il));
        check("u1 dir", 32'(dir_1), 32'(v.dr));
        check("u1 req_ready busy", 32'(req_ready1), 32'd0);
        check("u1 rsp_valid early", 32'(rsp_valid1), 32'd0);
        step();
        check("u1 rsp_valid", 32'(rsp_valid1), 32'd1);
        check("u1 rsp_result", rsp_result1, v.exp_result);
        check("u1 rsp_flag", 32'(rsp_flag1), 32'(v.exp_flag));
        step();
        check("u1 rsp_valid after hs", 32'(rsp_valid1), 32'd0);
        check("u1 req_ready after hs", 32'(req_ready1), 32'd1);
        check("u1 op_count", 32'(op_count1), 32'(v.exp_count));
    endtask

    vec_t vecs[5];
    vec_t v;

    initial begin
        vecs[0] = '{32'd20, 32'd10, 3'd0, 3'b010, 5'd0, 1'b0, 1'b0, 32'd30, 1'b1, 16'd1};
        vecs[1] = '{32'd5, 32'd9, 3'd7, 3'd5, 5'd31, 1'b1, 1'b0, 32'd14, 1'b0, 16'd2};
        vecs[2] = '{32'hFFFF_FFFF, 32'd1, 3'd2, 3'd7, 5'd16, 1'b0, 1'b1, 32'd0, 1'b1, 16'd3};
        vecs[3] = '{32'd7, 32'd7, 3'd5, 3'd1, 5'd1, 1'b1, 1'b1, 32'd14, 1'b0, 16'd4};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 3'd6, 3'd0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 16'd5};

        rst          = 1'b0;
        req_valid1   = 1'b0;
        req_valid4   = 1'b0;
        rsp_ready1   = 1'b0;
        rsp_ready4   = 1'b0;
        req_a        = 32'd0;
        req_b        = 32'd0;
        req_op       = 3'd0;
        req_flag_sel = 3'd0;
        req_shamt    = 5'd0;
        req_islog    = 1'b0;
        req_dir      = 1'b0;

        // reset state
        #7;
        check("reset req_ready", 32'(req_ready1), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid1), 32'd0);
        check("reset data1", data1_1, 32'd0);
        check("reset rsp_result", rsp_result1, 32'd0);
        check("reset op_count", 32'(op_count1), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // table-driven transactions, SETTLE_CYCLES=1
        for (int i = 0; i < 5; i++) begin
            run_vec1(vecs[i]);
        end

        // back-pressure, operand hold, ignored request, earliest re-accept
        v = '{32'd59, 32'd32, 3'd3, 3'd0, 5'd0, 1'b0, 1'b0, 32'd91, 1'b1, 16'd6};
        set_req(v);
        req_valid1 = 1'b1;
        rsp_ready1 = 1'b0;
        step();
        check("bp data1 accepted", data1_1, 32'd59);
        req_a = 32'd7;
        step();
        check("bp rsp_valid", 32'(rsp_valid1), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp rsp_result hold", rsp_result1, 32'd91);
            check("bp data1 hold", data1_1, 32'd59);
            check("bp req_ready low", 32'(req_ready1), 32'd0);
            check("bp rsp_valid hold", 32'(rsp_valid1), 32'd1);
            check("bp op_count hold", 32'(op_count1), 32'd5);
        end
        rsp_ready1 = 1'b1;
        step();
        check("bp back to idle", 32'(req_ready1), 32'd1);
        check("bp rsp_valid drop", 32'(rsp_valid1), 32'd0);
        check("bp op_count", 32'(op_count1), 32'd6);
        check("bp no accept on hs edge", data1_1, 32'd59);
        step();
        req_valid1 = 1'b0;
        check("re-accept data1", data1_1, 32'd7);
        step();
        check("re-accept rsp_result", rsp_result1, 32'd39);
        check("re-accept rsp_flag", 32'(rsp_flag1), 32'd0);
        step();
        check("re-accept op_count", 32'(op_count1), 32'd7);

        // SETTLE_CYCLES=4: shift fields and latency
        v = '{32'd987, 32'd983, 3'd4, 3'd0, 5'd3, 1'b1, 1'b1, 32'd1970, 1'b1, 16'd1};
        set_req(v);
        req_valid4 = 1'b1;
        rsp_ready4 = 1'b1;
        step();
        req_valid4 = 1'b0;
        check("u4 shamt", 32'(shamt_4), 32'd3);
        check("u4 isLog", 32'(islog_4), 32'd1);
        check("u4 dir", 32'(dir_4), 32'd1);
        check("u4 opSwitch", 32'(op_4), 32'd4);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("u4 rsp_valid edge %0d", k), 32'(rsp_valid4), (k == 4) ? 32'd1 : 32'd0);
        end
        check("u4 rsp_result", rsp_result4, 32'd1970);
        check("u4 rsp_flag", 32'(rsp_flag4), 32'd1);
        step();
        check("u4 op_count", 32'(op_count4), 32'd1);

        // asynchronous reset mid-DRIVE, plus accept on first edge after release
        v = '{32'd100, 32'd1, 3'd1, 3'd2, 5'd9, 1'b1, 1'b0, 32'd101, 1'b1, 16'd0};
        set_req(v);
        req_valid4 = 1'b1;
        step();
        req_valid4 = 1'b0;
        step();
        #2;
        rst = 1'b0;
        #1;
        check("arst u4 data1", data1_4, 32'd0);
        check("arst u4 shamt", 32'(shamt_4), 32'd0);
        check("arst u4 isLog", 32'(islog_4), 32'd0);
        check("arst u4 req_ready", 32'(req_ready4), 32'd1);
        check("arst u4 rsp_valid", 32'(rsp_valid4), 32'd0);
        check("arst u4 op_count", 32'(op_count4), 32'd0);
        check("arst u1 op_count", 32'(op_count1), 32'd0);
        req_a      = 32'd3;
        req_b      = 32'd4;
        req_valid1 = 1'b1;
        rsp_ready1 = 1'b1;
        #1;
        rst = 1'b1;
        step();
        req_valid1 = 1'b0;
        check("post-reset accept data1", data1_1, 32'd3);
        check("post-reset accept req_ready", 32'(req_ready1), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("arst u4 no rsp_valid", 32'(rsp_valid4), 32'd0);
            if (i == 0) begin
                check("post-reset rsp_result", rsp_result1, 32'd7);
                check("post-reset rsp_flag", 32'(rsp_flag1), 32'd0);
            end
            if (i == 1) begin
                check("post-reset op_count", 32'(op_count1), 32'd1);
            end
        end
        check("arst u4 op_count stays 0", 32'(op_count4), 32'd0);

        // counter wrap: preload 0xFFFF, then complete one more transaction
        force u1.op_count = 16'hFFFF;
        #1;
        release u1.op_count;
        #1;
        check("wrap preload", 32'(op_count1), 32'h0000_FFFF);
        @(negedge clk);
        v = '{32'd1, 32'd2, 3'd0, 3'd0, 5'd0, 1'b0, 1'b0, 32'd3, 1'b0, 16'h0000};
        run_vec1(v);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
